// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the DMA master state type.
// Pure definitions, no logic or latency.
// No flow control of its own; consumers apply HREADY handling.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        DONE
    } dma_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ahb_dma_master.sv
// Word-copy DMA engine: moves count words src->dst as single, non-pipelined AHB-Lite read/write pairs.
// Latency: 4 cycles per word plus one DONE cycle, stretched by slave wait states.
// Backpressure: HREADY low freezes every bus output; start is only accepted while idle.
module ahb_dma_master
    import ahb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dma_state_t       state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [CNT_W-1:0] remain_q;
    logic [31:0]      data_q;

    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA;
    assign HMASTLOCK = 1'b0;

    // Bus outputs are registered alongside the state so they change only on
    // the edge that moves the FSM; a stalled phase therefore holds them as-is.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            remain_q <= '0;
            data_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            HTRANS   <= HTRANS_IDLE;
            HADDR    <= '0;
            HWRITE   <= 1'b0;
            HWDATA   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q    <= word_align(src_addr);
                        dst_q    <= word_align(dst_addr);
                        remain_q <= count;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        if (count == CNT_ZERO) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= RD_ADDR;
                            HTRANS <= HTRANS_NONSEQ;
                            HADDR  <= word_align(src_addr);
                            HWRITE <= 1'b0;
                        end
                    end
                end
                RD_ADDR: begin
                    if (HREADY) begin
                        state  <= RD_DATA;
                        HTRANS <= HTRANS_IDLE;
                    end
                end
                RD_DATA: begin
                    if (HRESP) begin
                        // Error response: abandon the command, the read data is never written.
                        HTRANS <= HTRANS_IDLE;
                        if (HREADY) begin
                            error <= 1'b1;
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (HREADY) begin
                        data_q <= HRDATA;
                        state  <= WR_ADDR;
                        HTRANS <= HTRANS_NONSEQ;
                        HADDR  <= dst_q;
                        HWRITE <= 1'b1;
                    end
                end
                WR_ADDR: begin
                    if (HREADY) begin
                        state  <= WR_DATA;
                        HTRANS <= HTRANS_IDLE;
                        HWDATA <= data_q;
                    end
                end
                WR_DATA: begin
                    if (HRESP) begin
                        HTRANS <= HTRANS_IDLE;
                        if (HREADY) begin
                            error  <= 1'b1;
                            HWDATA <= '0;
                            state  <= DONE;
                            done   <= 1'b1;
                        end
                    end else if (HREADY) begin
                        HWDATA   <= '0;
                        src_q    <= src_q + 32'd4;
                        dst_q    <= dst_q + 32'd4;
                        remain_q <= remain_q - CNT_ONE;
                        if (remain_q == CNT_ONE) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= RD_ADDR;
                            HTRANS <= HTRANS_NONSEQ;
                            HADDR  <= src_q + 32'd4;
                            HWRITE <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    HTRANS <= HTRANS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_dma_master.sv
// Bench for ahb_dma_master: behavioural AHB-Lite slave with a sparse memory,
// plus a copy model built from word lists (reads at src+4i, writes at dst+4i).
module tb_ahb_dma_master;

    localparam int CNT_W = 16;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             error;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic [3:0]       HPROT;
    logic             HMASTLOCK;
    logic [31:0]      HWDATA;
    logic [31:0]      HRDATA;
    logic             HREADY;
    logic             HRESP;

    always #5 HCLK = ~HCLK;

    ahb_dma_master #(.CNT_W(CNT_W)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
        .busy(busy), .done(done), .error(error),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int checks = 0;
    int passed = 0;

    // Slave configuration and activity logs.
    int          wait_cfg = 0;
    bit          rand_waits = 1'b0;
    int          err_read_idx = 0;
    logic [31:0] seed;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_dat_log[$];
    int nonseq_cnt, done_cnt, busy_cnt, wait_total, n_reads, stable_viol;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    // Slave + monitor: decides HREADY/HRESP/HRDATA for the coming edge at each negedge.
    initial begin : slave
        bit          dp_on, dp_write, prev_valid, prev_ready;
        int          dp_wait, dp_err;
        logic [31:0] dp_addr, p_haddr, p_hwdata;
        logic [1:0]  p_htrans;
        logic        p_hwrite;
        dp_on = 0; dp_write = 0; dp_wait = 0; dp_err = 0; dp_addr = '0;
        prev_valid = 0; prev_ready = 1;
        p_haddr = '0; p_hwdata = '0; p_htrans = '0; p_hwrite = 0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        forever begin
            @(negedge HCLK);
            if (HRESET === 1'b1) begin
                dp_on = 0; HREADY = 1'b1; HRESP = 1'b0; prev_valid = 0;
                continue;
            end
            if (prev_valid && !prev_ready) begin
                if (HADDR !== p_haddr || HTRANS !== p_htrans || HWRITE !== p_hwrite || HWDATA !== p_hwdata)
                    stable_viol++;
            end
            if (HTRANS === 2'b10) nonseq_cnt++;
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cnt++;
            HRESP = 1'b0; HREADY = 1'b1;
            if (dp_on) begin
                if (dp_err > 0) begin
                    HRESP = 1'b1;
                    HREADY = (dp_err == 1);
                    dp_err--;
                    if (dp_err == 0) dp_on = 0;
                end else if (dp_wait > 0) begin
                    HREADY = 1'b0;
                    dp_wait--;
                    wait_total++;
                end else begin
                    if (dp_write) begin
                        wr_addr_log.push_back(dp_addr);
                        wr_dat_log.push_back(HWDATA);
                        mem[dp_addr] = HWDATA;
                    end else begin
                        HRDATA = rd_word(dp_addr);
                    end
                    dp_on = 0;
                end
            end else if (HTRANS === 2'b10) begin
                dp_on = 1; dp_addr = HADDR; dp_write = HWRITE; dp_err = 0;
                dp_wait = rand_waits ? int'($urandom_range(0, 2)) : wait_cfg;
                if (!HWRITE) begin
                    n_reads++;
                    rd_log.push_back(HADDR);
                    if (n_reads == err_read_idx) begin dp_err = 2; dp_wait = 0; end
                end
            end
            prev_valid = 1; prev_ready = HREADY;
            p_haddr = HADDR; p_htrans = HTRANS; p_hwrite = HWRITE; p_hwdata = HWDATA;
        end
    end

    task automatic clear_logs();
        rd_log.delete(); wr_addr_log.delete(); wr_dat_log.delete();
        nonseq_cnt = 0; done_cnt = 0; busy_cnt = 0; wait_total = 0; n_reads = 0; stable_viol = 0;
    endtask

    // Issues one command; dcyc is the cycle (counted from the start edge) in which done is seen, -1 on timeout.
    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int n, output int dcyc);
        @(negedge HCLK);
        clear_logs();
        src_addr = s; dst_addr = d; count = CNT_W'(n); start = 1'b1;
        @(posedge HCLK);
        #1 start = 1'b0;
        dcyc = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge HCLK);
            if (done === 1'b1) begin dcyc = i; break; end
        end
        repeat (2) @(negedge HCLK);
    endtask

    task automatic test_reset();
        HRESET = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; count = '0;
        repeat (3) @(posedge HCLK);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL reset_error got %b exp 0", error); else passed++;
        checks++; if (HTRANS !== 2'b00) $display("FAIL reset_htrans got %b exp 00", HTRANS); else passed++;
        checks++; if (HADDR !== 32'h0) $display("FAIL reset_haddr got %h exp 0", HADDR); else passed++;
        checks++; if (HWRITE !== 1'b0) $display("FAIL reset_hwrite got %b exp 0", HWRITE); else passed++;
        checks++; if (HWDATA !== 32'h0) $display("FAIL reset_hwdata got %h exp 0", HWDATA); else passed++;
        checks++;
        if ({HSIZE, HBURST, HPROT, HMASTLOCK} !== {3'b010, 3'b000, 4'b0011, 1'b0})
            $display("FAIL const_outputs got %b_%b_%b_%b exp 010_000_0011_0", HSIZE, HBURST, HPROT, HMASTLOCK);
        else passed++;
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    task automatic test_basic_copy();
        int dc;
        logic [31:0] er, ew;
        wait_cfg = 0; rand_waits = 0; err_read_idx = 0;
        run_cmd(32'h0000_0000, 32'h0000_0100, 3, dc);
        checks++; if (dc !== 13) $display("FAIL basic_done_cycle got %0d exp 13", dc); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL basic_done_pulses got %0d exp 1", done_cnt); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL basic_error got %b exp 0", error); else passed++;
        checks++;
        if (rd_log.size() !== 3 || wr_addr_log.size() !== 3)
            $display("FAIL basic_xfer_count got rd=%0d wr=%0d exp 3/3", rd_log.size(), wr_addr_log.size());
        else passed++;
        for (int i = 0; i < 3 && i < rd_log.size() && i < wr_addr_log.size(); i++) begin
            er = 32'(4 * i);
            ew = 32'h100 + 32'(4 * i);
            checks++;
            if (rd_log[i] !== er || wr_addr_log[i] !== ew || wr_dat_log[i] !== rd_word(er) || mem[ew] !== rd_word(er))
                $display("FAIL basic_word%0d got rd=%h wr=%h dat=%h exp rd=%h wr=%h dat=%h",
                         i, rd_log[i], wr_addr_log[i], wr_dat_log[i], er, ew, rd_word(er));
            else passed++;
        end
    endtask

    task automatic test_zero_count();
        int dc;
        wait_cfg = 0; rand_waits = 0; err_read_idx = 0;
        run_cmd(32'h0000_0040, 32'h0000_0200, 0, dc);
        checks++; if (dc !== 1) $display("FAIL zero_done_cycle got %0d exp 1", dc); else passed++;
        checks++; if (nonseq_cnt !== 0) $display("FAIL zero_nonseq got %0d exp 0", nonseq_cnt); else passed++;
        checks++; if (busy_cnt !== 1) $display("FAIL zero_busy_cycles got %0d exp 1", busy_cnt); else passed++;
    endtask

    task automatic test_wait_states();
        int dc;
        logic [31:0] er, ew;
        wait_cfg = 2; rand_waits = 0; err_read_idx = 0;
        run_cmd(32'h0000_0040, 32'h0000_0300, 2, dc);
        // 2 words x 2 data phases x 2 waits = 8 stall cycles on top of 4N+1.
        checks++; if (wait_total !== 8) $display("FAIL waits_inserted got %0d exp 8", wait_total); else passed++;
        checks++; if (dc !== 17) $display("FAIL waits_done_cycle got %0d exp 17", dc); else passed++;
        checks++; if (stable_viol !== 0) $display("FAIL waits_stability got %0d changes exp 0", stable_viol); else passed++;
        checks++;
        if (wr_addr_log.size() !== 2) $display("FAIL waits_writes got %0d exp 2", wr_addr_log.size()); else passed++;
        for (int i = 0; i < 2 && i < wr_addr_log.size() && i < rd_log.size(); i++) begin
            er = 32'h40 + 32'(4 * i);
            ew = 32'h300 + 32'(4 * i);
            checks++;
            if (rd_log[i] !== er || wr_addr_log[i] !== ew || wr_dat_log[i] !== rd_word(er))
                $display("FAIL waits_word%0d got rd=%h wr=%h dat=%h exp rd=%h wr=%h dat=%h",
                         i, rd_log[i], wr_addr_log[i], wr_dat_log[i], er, ew, rd_word(er));
            else passed++;
        end
    endtask

    task automatic test_error();
        int dc;
        wait_cfg = 0; rand_waits = 0; err_read_idx = 2;
        run_cmd(32'h0000_1000, 32'h0000_2000, 4, dc);
        err_read_idx = 0;
        // Word 1 (4 cycles), read address (1), two error-response cycles, then DONE.
        checks++; if (dc !== 8) $display("FAIL err_done_cycle got %0d exp 8", dc); else passed++;
        checks++; if (error !== 1'b1) $display("FAIL err_flag got %b exp 1", error); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL err_done_pulses got %0d exp 1", done_cnt); else passed++;
        checks++;
        if (wr_addr_log.size() !== 1 || rd_log.size() !== 2)
            $display("FAIL err_xfers got wr=%0d rd=%0d exp 1/2", wr_addr_log.size(), rd_log.size());
        else passed++;
        checks++; if (nonseq_cnt !== 3) $display("FAIL err_nonseq_after got %0d exp 3", nonseq_cnt); else passed++;
        checks++; if (stable_viol !== 0) $display("FAIL err_stability got %0d exp 0", stable_viol); else passed++;
        repeat (3) @(negedge HCLK);
        checks++; if (error !== 1'b1) $display("FAIL err_sticky got %b exp 1", error); else passed++;
        run_cmd(32'h0000_1100, 32'h0000_2100, 1, dc);
        checks++; if (error !== 1'b0) $display("FAIL err_cleared got %b exp 0", error); else passed++;
    endtask

    task automatic test_addr_wrap();
        int dc;
        wait_cfg = 0; rand_waits = 0; err_read_idx = 0;
        run_cmd(32'hFFFF_FFFC, 32'h0000_3000, 2, dc);
        checks++;
        if (rd_log.size() !== 2 || rd_log[1] !== 32'h0) $display("FAIL wrap_second_read got %h exp 00000000", rd_log[1]);
        else passed++;
        run_cmd(32'h0000_0103, 32'h0000_3103, 1, dc);
        checks++;
        if (rd_log.size() !== 1 || rd_log[0] !== 32'h100) $display("FAIL align_src got %h exp 00000100", rd_log[0]);
        else passed++;
        checks++;
        if (wr_addr_log.size() !== 1 || wr_addr_log[0] !== 32'h3100) $display("FAIL align_dst got %h exp 00003100", wr_addr_log[0]);
        else passed++;
    endtask

    task automatic test_random();
        int dc, n, bad;
        logic [31:0] s, d, er, ew;
        wait_cfg = 0; rand_waits = 1; err_read_idx = 0;
        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 5));
            s = 32'h0001_0000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
            d = 32'h0008_0000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
            run_cmd(s, d, n, dc);
            checks++;
            if (dc !== 4 * n + 1 + wait_total)
                $display("FAIL rand%0d_done_cycle got %0d exp %0d", t, dc, 4 * n + 1 + wait_total);
            else passed++;
            bad = (rd_log.size() != n || wr_addr_log.size() != n) ? 1 : 0;
            for (int i = 0; i < n && bad == 0; i++) begin
                er = (s & 32'hFFFF_FFFC) + 32'(4 * i);
                ew = (d & 32'hFFFF_FFFC) + 32'(4 * i);
                if (rd_log[i] !== er || wr_addr_log[i] !== ew || wr_dat_log[i] !== rd_word(er)) bad = i + 2;
            end
            checks++;
            if (bad != 0) $display("FAIL rand%0d_copy got bad_code %0d exp 0 (n=%0d src=%h dst=%h)", t, bad, n, s, d);
            else passed++;
            checks++;
            if (stable_viol !== 0) $display("FAIL rand%0d_stability got %0d exp 0", t, stable_viol); else passed++;
        end
        rand_waits = 0;
    endtask

    task automatic test_reset_midway();
        int guard;
        wait_cfg = 1; rand_waits = 0; err_read_idx = 0;
        @(negedge HCLK);
        clear_logs();
        src_addr = 32'h0000_0500; dst_addr = 32'h0000_0600; count = CNT_W'(3); start = 1'b1;
        @(posedge HCLK);
        #1 start = 1'b0;
        @(negedge HCLK);
        src_addr = 32'h0000_AB00; dst_addr = 32'h0000_CD00; count = CNT_W'(7); start = 1'b1;
        @(posedge HCLK);
        #1 start = 1'b0;
        guard = 0;
        while (!(HWRITE === 1'b1 && HTRANS === 2'b00 && busy === 1'b1) && guard < 50) begin
            @(negedge HCLK);
            guard++;
        end
        checks++; if (guard >= 50) $display("FAIL midrst_reach_wr_data got timeout exp WR_DATA"); else passed++;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else passed++;
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWDATA !== 32'h0)
            $display("FAIL midrst_bus got htrans=%b haddr=%h hwdata=%h exp 00/0/0", HTRANS, HADDR, HWDATA);
        else passed++;
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        repeat (5) @(negedge HCLK);
        checks++; if (done_cnt !== 0) $display("FAIL midrst_done_pulses got %0d exp 0", done_cnt); else passed++;
        checks++;
        if (rd_log.size() !== 1 || rd_log[0] !== 32'h500 || wr_addr_log.size() !== 0)
            $display("FAIL midrst_start_ignored got rd=%0d first=%h wr=%0d exp 1/00000500/0",
                     rd_log.size(), rd_log[0], wr_addr_log.size());
        else passed++;
        checks++; if (busy !== 1'b0 || HTRANS !== 2'b00) $display("FAIL midrst_stays_idle got busy=%b htrans=%b exp 0/00", busy, HTRANS);
        else passed++;
        wait_cfg = 0;
    endtask

    initial begin
        seed = $urandom;
        test_reset();
        test_basic_copy();
        test_zero_count();
        test_wait_states();
        test_error();
        test_addr_wrap();
        test_random();
        test_reset_midway();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
